// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: per-stage ready/flush generation, Q102H forwarding selects,
// data-memory wait FSM, stall/flush performance counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_Q101H,
  input  logic [4:0]       rs2_Q101H,
  input  logic             rs1_used_Q101H,
  input  logic             rs2_used_Q101H,
  input  logic [4:0]       rd_Q102H,
  input  logic             dmem_rd_en_Q102H,
  input  logic [4:0]       rs1_Q102H,
  input  logic [4:0]       rs2_Q102H,
  input  logic [4:0]       rd_Q103H,
  input  logic             reg_write_en_Q103H,
  input  logic [4:0]       rd_Q104H,
  input  logic             reg_write_en_Q104H,
  input  logic             sel_next_pc_alu_out_Q102H,
  input  logic             dmem_req_Q103H,
  input  logic             dmem_ack,
  output logic             ready_Q100H,
  output logic             ready_Q101H,
  output logic             ready_Q102H,
  output logic             ready_Q103H,
  output logic             ready_Q104H,
  output logic             flush_Q101H,
  output logic             flush_Q102H,
  output logic [1:0]       fwd_sel_rs1_Q102H,
  output logic [1:0]       fwd_sel_rs2_Q102H,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic mem_wait;
  logic branch_flush;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd3, input logic we3,
                                         input logic [4:0] rd4, input logic we4);
    logic [1:0] sel;
    sel = 2'b00;
    if (we3 && (rd3 != 5'd0) && (rd3 == rs)) begin
      sel = 2'b01;
    end else if (we4 && (rd4 != 5'd0) && (rd4 == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Hazard classification, highest priority first: memory wait, branch flush, load-use.
  always_comb begin
    rs1_hit      = rs1_used_Q101H && (rs1_Q101H == rd_Q102H);
    rs2_hit      = rs2_used_Q101H && (rs2_Q101H == rd_Q102H);
    mem_wait     = ~dmem_ack & ((state_q == StMemWait) | dmem_req_Q103H);
    branch_flush = ~mem_wait & sel_next_pc_alu_out_Q102H;
    load_use     = ~mem_wait & ~sel_next_pc_alu_out_Q102H & dmem_rd_en_Q102H &
                   (rd_Q102H != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Outputs are forced inactive for as long as reset is held, independent of the inputs.
  always_comb begin
    ready_Q100H       = 1'b0;
    ready_Q101H       = 1'b0;
    ready_Q102H       = 1'b0;
    ready_Q103H       = 1'b0;
    ready_Q104H       = 1'b0;
    flush_Q101H       = 1'b0;
    flush_Q102H       = 1'b0;
    fwd_sel_rs1_Q102H = 2'b00;
    fwd_sel_rs2_Q102H = 2'b00;
    if (rst_n) begin
      ready_Q100H       = 1'b1;
      ready_Q101H       = 1'b1;
      ready_Q102H       = 1'b1;
      ready_Q103H       = 1'b1;
      ready_Q104H       = 1'b1;
      fwd_sel_rs1_Q102H = fwd_sel(rs1_Q102H, rd_Q103H, reg_write_en_Q103H,
                                  rd_Q104H, reg_write_en_Q104H);
      fwd_sel_rs2_Q102H = fwd_sel(rs2_Q102H, rd_Q103H, reg_write_en_Q103H,
                                  rd_Q104H, reg_write_en_Q104H);
      if (mem_wait) begin
        // Write-back still drains; the Q104H control struct inserts the bubble behind it.
        ready_Q100H = 1'b0;
        ready_Q101H = 1'b0;
        ready_Q102H = 1'b0;
        ready_Q103H = 1'b0;
      end else if (branch_flush) begin
        flush_Q101H = 1'b1;
        flush_Q102H = 1'b1;
      end else if (load_use) begin
        ready_Q100H = 1'b0;
        ready_Q101H = 1'b0;
        flush_Q102H = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (mem_wait || load_use) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_flush) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StRun: begin
        if (dmem_req_Q103H && !dmem_ack) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (wait_cnt_q != WaitMax) begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
        // The flag only reports; the pipe keeps waiting for the ack.
        if (wait_cnt_d == WaitMax) begin
          err_d = 1'b1;
        end
        if (dmem_ack) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model of the
// hazard rules, plus directed scenarios for reset, penalties, timeout and forwarding.
module tb_pipe_hazard_ctrl;

  localparam int unsigned Timeout = 4;
  localparam int unsigned CntW    = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      rs1_Q101H, rs2_Q101H, rd_Q102H, rs1_Q102H, rs2_Q102H, rd_Q103H, rd_Q104H;
  logic            rs1_used_Q101H, rs2_used_Q101H, dmem_rd_en_Q102H;
  logic            reg_write_en_Q103H, reg_write_en_Q104H;
  logic            sel_next_pc_alu_out_Q102H, dmem_req_Q103H, dmem_ack;
  logic            ready_Q100H, ready_Q101H, ready_Q102H, ready_Q103H, ready_Q104H;
  logic            flush_Q101H, flush_Q102H;
  logic [1:0]      fwd_sel_rs1_Q102H, fwd_sel_rs2_Q102H;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic            mem_timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit m_wait;
  int m_wait_cycles;
  bit m_err;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(Timeout),
    .CNT_W      (CntW)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .rs1_Q101H                (rs1_Q101H),
    .rs2_Q101H                (rs2_Q101H),
    .rs1_used_Q101H           (rs1_used_Q101H),
    .rs2_used_Q101H           (rs2_used_Q101H),
    .rd_Q102H                 (rd_Q102H),
    .dmem_rd_en_Q102H         (dmem_rd_en_Q102H),
    .rs1_Q102H                (rs1_Q102H),
    .rs2_Q102H                (rs2_Q102H),
    .rd_Q103H                 (rd_Q103H),
    .reg_write_en_Q103H       (reg_write_en_Q103H),
    .rd_Q104H                 (rd_Q104H),
    .reg_write_en_Q104H       (reg_write_en_Q104H),
    .sel_next_pc_alu_out_Q102H(sel_next_pc_alu_out_Q102H),
    .dmem_req_Q103H           (dmem_req_Q103H),
    .dmem_ack                 (dmem_ack),
    .ready_Q100H              (ready_Q100H),
    .ready_Q101H              (ready_Q101H),
    .ready_Q102H              (ready_Q102H),
    .ready_Q103H              (ready_Q103H),
    .ready_Q104H              (ready_Q104H),
    .flush_Q101H              (flush_Q101H),
    .flush_Q102H              (flush_Q102H),
    .fwd_sel_rs1_Q102H        (fwd_sel_rs1_Q102H),
    .fwd_sel_rs2_Q102H        (fwd_sel_rs2_Q102H),
    .stall_cnt                (stall_cnt),
    .flush_cnt                (flush_cnt),
    .mem_timeout_err          (mem_timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ready_vec();
    return {ready_Q104H, ready_Q103H, ready_Q102H, ready_Q101H, ready_Q100H};
  endfunction

  // Youngest writer with a non-zero destination wins.
  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (reg_write_en_Q103H && rd_Q103H != 5'd0 && rd_Q103H == rs) return 2'b01;
    if (reg_write_en_Q104H && rd_Q104H != 5'd0 && rd_Q104H == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_idle();
    rs1_Q101H = 5'd0; rs2_Q101H = 5'd0; rs1_used_Q101H = 1'b0; rs2_used_Q101H = 1'b0;
    rd_Q102H = 5'd0; dmem_rd_en_Q102H = 1'b0; rs1_Q102H = 5'd0; rs2_Q102H = 5'd0;
    rd_Q103H = 5'd0; reg_write_en_Q103H = 1'b0; rd_Q104H = 5'd0; reg_write_en_Q104H = 1'b0;
    sel_next_pc_alu_out_Q102H = 1'b0; dmem_req_Q103H = 1'b0; dmem_ack = 1'b0;
  endtask

  // One clock cycle: compare all outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit stall, bflush, lu, hit;
    logic [4:0] rdy;
    logic [1:0] fl;
    @(negedge clk);
    stall  = !dmem_ack && (m_wait || dmem_req_Q103H);
    bflush = !stall && sel_next_pc_alu_out_Q102H;
    hit    = (rs1_used_Q101H && rs1_Q101H == rd_Q102H) ||
             (rs2_used_Q101H && rs2_Q101H == rd_Q102H);
    lu     = !stall && !sel_next_pc_alu_out_Q102H && dmem_rd_en_Q102H &&
             rd_Q102H != 5'd0 && hit;
    rdy = stall ? 5'b10000 : (lu ? 5'b11100 : 5'b11111);
    fl  = bflush ? 2'b11 : (lu ? 2'b10 : 2'b00);
    check("ready", 32'(ready_vec()), 32'(rdy));
    check("flush", 32'({flush_Q102H, flush_Q101H}), 32'(fl));
    check("fwd_rs1", 32'(fwd_sel_rs1_Q102H), 32'(fwd_ref(rs1_Q102H)));
    check("fwd_rs2", 32'(fwd_sel_rs2_Q102H), 32'(fwd_ref(rs2_Q102H)));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall % (1 << CntW)));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush % (1 << CntW)));
    check("timeout_err", 32'(mem_timeout_err), 32'(m_err));
    if (stall || lu) m_stall++;
    if (bflush) m_flush++;
    if (m_wait) begin
      m_wait_cycles++;
      if (m_wait_cycles >= Timeout) m_err = 1'b1;
      if (dmem_ack) m_wait = 1'b0;
    end else if (dmem_req_Q103H && !dmem_ack) begin
      m_wait        = 1'b1;
      m_wait_cycles = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with inputs that would otherwise stall, flush and forward.
  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    dmem_req_Q103H = 1'b1; sel_next_pc_alu_out_Q102H = 1'b1;
    dmem_rd_en_Q102H = 1'b1; rd_Q102H = 5'd3; rs1_Q101H = 5'd3; rs1_used_Q101H = 1'b1;
    rs1_Q102H = 5'd7; rd_Q103H = 5'd7; reg_write_en_Q103H = 1'b1;
    #2;
    check("rst_ready", 32'(ready_vec()), 32'd0);
    check("rst_flush", 32'({flush_Q102H, flush_Q101H}), 32'd0);
    check("rst_fwd", 32'({fwd_sel_rs2_Q102H, fwd_sel_rs1_Q102H}), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_err", 32'(mem_timeout_err), 32'd0);
    m_wait = 1'b0; m_wait_cycles = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    @(posedge clk);
    #1;

    // Release with a request still pending: Q103H holds, write-back drains.
    do_reset();
    set_idle();
    dmem_req_Q103H = 1'b1;
    #1;
    check("rel_ready_q103", 32'(ready_Q103H), 32'd0);
    check("rel_ready_q104", 32'(ready_Q104H), 32'd1);
    cycle();
    dmem_ack = 1'b1;
    cycle();

    // Load-use: one bubble, then the rd=0 and unused-source variants do not stall.
    do_reset();
    set_idle();
    dmem_rd_en_Q102H = 1'b1; rd_Q102H = 5'd5; rs2_Q101H = 5'd5; rs2_used_Q101H = 1'b1;
    cycle();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    rd_Q102H = 5'd0; rs2_Q101H = 5'd0;
    cycle();
    rd_Q102H = 5'd5; rs2_Q101H = 5'd5; rs2_used_Q101H = 1'b0;
    cycle();
    check("lu_nostall_cnt", 32'(stall_cnt), 32'd1);

    // Branch wins over load-use in the same cycle.
    rs2_used_Q101H = 1'b1; sel_next_pc_alu_out_Q102H = 1'b1;
    #1;
    check("br_lu_ready", 32'(ready_vec()), 32'h1f);
    check("br_lu_flush", 32'({flush_Q102H, flush_Q101H}), 32'h3);
    cycle();
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait of 3 cycles with a branch held in Q102H: flush only in the ack cycle.
    do_reset();
    set_idle();
    dmem_req_Q103H = 1'b1; sel_next_pc_alu_out_Q102H = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    dmem_ack = 1'b1;
    cycle();
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw_flush_cnt", 32'(flush_cnt), 32'd1);

    // Timeout: flag rises after the 4th wait cycle and survives the ack.
    do_reset();
    set_idle();
    dmem_req_Q103H = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("timeout_rise", 32'(mem_timeout_err), (i >= 4) ? 32'd1 : 32'd0);
    end
    dmem_ack = 1'b1;
    cycle();
    set_idle();
    cycle();
    check("timeout_sticky", 32'(mem_timeout_err), 32'd1);
    do_reset();
    set_idle();
    #1;
    check("timeout_cleared", 32'(mem_timeout_err), 32'd0);

    // Forwarding priority.
    rs1_Q102H = 5'd7; rd_Q103H = 5'd7; rd_Q104H = 5'd7;
    reg_write_en_Q103H = 1'b1; reg_write_en_Q104H = 1'b1;
    #1;
    check("fwd_q103", 32'(fwd_sel_rs1_Q102H), 32'd1);
    reg_write_en_Q103H = 1'b0;
    #1;
    check("fwd_q104", 32'(fwd_sel_rs1_Q102H), 32'd2);
    reg_write_en_Q103H = 1'b1; rs1_Q102H = 5'd0; rd_Q103H = 5'd0; rd_Q104H = 5'd0;
    #1;
    check("fwd_x0", 32'(fwd_sel_rs1_Q102H), 32'd0);
    cycle();

    // Randomized traffic with periodic resets, some of them mid-wait.
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 299) do_reset();
      rs1_Q101H = 5'($urandom_range(0, 7));
      rs2_Q101H = 5'($urandom_range(0, 7));
      rs1_used_Q101H = 1'($urandom_range(0, 1));
      rs2_used_Q101H = 1'($urandom_range(0, 1));
      rd_Q102H = 5'($urandom_range(0, 7));
      dmem_rd_en_Q102H = ($urandom_range(0, 99) < 40);
      rs1_Q102H = 5'($urandom_range(0, 7));
      rs2_Q102H = 5'($urandom_range(0, 7));
      rd_Q103H = 5'($urandom_range(0, 7));
      reg_write_en_Q103H = 1'($urandom_range(0, 1));
      rd_Q104H = 5'($urandom_range(0, 7));
      reg_write_en_Q104H = 1'($urandom_range(0, 1));
      sel_next_pc_alu_out_Q102H = ($urandom_range(0, 99) < 20);
      dmem_req_Q103H = ($urandom_range(0, 99) < 30);
      dmem_ack = ($urandom_range(0, 99) < 30);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline control for the five-stage core (Q100H fetch to Q104H write-back). It produces the per-stage `ready_*` signals consumed by the IF/EXE/MA/WB control structs, the bubble/flush strobes, and the Q102H forwarding selects. It also runs a small FSM that holds the pipe while a data-memory access in Q103H is outstanding, and keeps stall/flush performance counters plus a sticky memory-timeout flag.

## Interface
- `MEM_TIMEOUT`, default 255: wait cycles in MEM_WAIT before `mem_timeout_err` is set.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs1_Q101H`, `rs2_Q101H` in 5 each: source registers of the instruction in decode.
- `rs1_used_Q101H`, `rs2_used_Q101H` in 1 each: decode instruction reads that source.
- `rd_Q102H` in 5: destination register in Q102H.
- `dmem_rd_en_Q102H` in 1: instruction in Q102H is a load.
- `rs1_Q102H`, `rs2_Q102H` in 5 each: sources in Q102H, used for forwarding.
- `rd_Q103H`, `reg_write_en_Q103H`, `rd_Q104H`, `reg_write_en_Q104H` in 5/1/5/1: forwarding producers.
- `sel_next_pc_alu_out_Q102H` in 1: taken branch or jump resolved in Q102H.
- `dmem_req_Q103H` in 1: `dmem_rd_en_Q103H | dmem_wr_en_Q103H`.
- `dmem_ack` in 1: memory completes the Q103H access this cycle.
- `ready_Q100H` … `ready_Q104H` out 1 each: stage may advance.
- `flush_Q101H`, `flush_Q102H` out 1 each: the register feeding that stage loads a bubble.
- `fwd_sel_rs1_Q102H`, `fwd_sel_rs2_Q102H` out 2 each: 00 = register file, 01 = Q103H ALU result, 10 = Q104H write-back data.
- `stall_cnt`, `flush_cnt` out CNT_W each: performance counters.
- `mem_timeout_err` out 1: sticky timeout flag.

## Operation
- **FSM states**
  - RUN to MEM_WAIT when `dmem_req_Q103H & ~dmem_ack`.
  - MEM_WAIT to RUN on `dmem_ack`.
  - A request acked in the same cycle it appears never leaves RUN.
- **Memory wait** (condition: MEM_WAIT, or RUN with `dmem_req_Q103H & ~dmem_ack`)
  - `ready_Q100H` through `ready_Q103H` = 0.
  - `ready_Q104H` = 1, and Q104H receives a bubble.
  - All flushes are suppressed. This condition has the highest priority.
- **Branch flush** (condition: not in memory wait and `sel_next_pc_alu_out_Q102H`)
  - `flush_Q101H` = `flush_Q102H` = 1.
  - All ready outputs = 1.
  - Load-use detection is ignored, because the dependent instruction is being flushed.
- **Load-use stall** (condition: `dmem_rd_en_Q102H`, `rd_Q102H` != 0, and a used `rs1/rs2_Q101H` == `rd_Q102H`)
  - `ready_Q100H` = `ready_Q101H` = 0.
  - `flush_Q102H` = 1.
  - `ready_Q102H` through `ready_Q104H` = 1.
- **Otherwise:** all ready outputs = 1, all flushes = 0.
- **Forwarding** (per source, combinational, independent of stalls)
  - Q103H match (`reg_write_en_Q103H` & rd != 0 & rd == rs) selects 01.
  - Otherwise a Q104H match selects 10.
  - Otherwise 00.
  - Q103H has priority over Q104H.
- **Counters**
  - `stall_cnt` increments in every cycle with a memory-wait or load-use stall.
  - `flush_cnt` increments in every cycle a branch flush is issued.
  - Both wrap modulo 2^CNT_W.
- **Timeout**
  - A wait counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle, saturating.
  - When it reaches MEM_TIMEOUT, `mem_timeout_err` is set to 1 and stays 1 until reset.
  - The pipe keeps waiting after the flag is set.

## Timing
- Ready, flush and forwarding outputs are combinational from the inputs and the registered FSM state, so they are valid in the same cycle.
- State, counters and the error flag update on `posedge clk`.
- **Reset** (`rst_n` = 0, asynchronous)
  - State = RUN; counters = 0; `mem_timeout_err` = 0.
  - All `ready_*` = 0, all flushes = 0, fwd selects = 00, forced regardless of inputs.
  - Normal outputs resume in the first cycle after `rst_n` rises.
- Reset asserted mid-MEM_WAIT abandons the wait immediately. No outstanding access is remembered.
- **Penalties**
  - Load-use: exactly 1 bubble.
  - Taken branch: 2 bubbles.
  - Memory wait: N stall cycles for an ack arriving N cycles after the request.
- A branch held in Q102H during MEM_WAIT flushes in the first cycle the ack arrives, and not before.
- Load-use and a memory wait in the same cycle count as one stall cycle.

## Test plan
- **Reset:** hold `rst_n` = 0 with `dmem_req_Q103H` = 1 and branch = 1 → all ready = 0, all flushes = 0, counters = 0. Release → `ready_Q103H` = 0, `ready_Q104H` = 1.
- **Load-use:** load `rd_Q102H` = 5 with `rs2_Q101H` = 5 used → `ready_Q100H/Q101H` = 0 and `flush_Q102H` = 1 for 1 cycle; `stall_cnt` = 1. The same case with rd = 0 or `rs2_used` = 0 → no stall.
- **Branch with load-use in the same cycle:** → `flush_Q101H` = `flush_Q102H` = 1, all ready = 1, `flush_cnt` = 1, `stall_cnt` unchanged.
- **Memory wait:** request with ack 3 cycles later → `ready_Q100H..Q103H` = 0 for 3 cycles, `ready_Q104H` = 1, `stall_cnt` = 3. Add a branch held in Q102H → flush appears only in the ack cycle.
- **Timeout:** `MEM_TIMEOUT` = 4, ack withheld 10 cycles → `mem_timeout_err` rises after the 4th MEM_WAIT cycle and stays 1 after the ack. Then pulse `rst_n` low → flag = 0.
- **Forwarding:** rs1 = 7 with both `rd_Q103H` and `rd_Q104H` = 7 writing → 01. Drop the Q103H write → 10. rd = 0 in both → 00.
